// File: rtl/redmule_pkg.sv
// redmule_pkg: shared widths, Z packer FSM state, config record and strobe helper
package redmule_pkg;
  localparam int unsigned DATA_W      = 288;
  localparam int unsigned MEM_DW      = 32;
  localparam int unsigned BITW        = 16;
  localparam int unsigned TOT_DEPTH   = 16;
  localparam int unsigned DATAW       = TOT_DEPTH * BITW;
  localparam int unsigned ARRAY_WIDTH = 12;
  localparam int unsigned STRB        = DATA_W / 8;
  localparam int unsigned CNT_W       = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} z_packer_state_e;
  typedef struct packed {
    logic [CNT_W-1:0] tot_stores;
    logic [CNT_W-1:0] n_col_tiles;
    logic [CNT_W-1:0] n_row_blocks;
    logic [7:0]       cols_lftovr;
    logic [7:0]       rows_lftovr;
  } z_packer_cfg_t;
  function automatic logic [STRB-1:0] col_strb(input logic [7:0] cols);
    logic [7:0] n;
    n = (cols == 8'd0 || cols > 8'(TOT_DEPTH)) ? 8'(TOT_DEPTH) : cols;
    for (int unsigned i = 0; i < STRB; i++) col_strb[i] = i < {23'd0, n, 1'b0};
  endfunction
endpackage

// File: rtl/redmule_z_store_packer_if.sv
// redmule_z_store_packer_if: Z row input stream plus TCDM store beat output stream; master = packer side
interface redmule_z_store_packer_if;
  import redmule_pkg::*;
  logic [DATAW-1:0]  z_data;
  logic              z_valid;
  logic              z_ready;
  logic [DATA_W-1:0] data;
  logic [STRB-1:0]   strb;
  logic              valid;
  logic              ready;
  modport master (input z_data, z_valid, ready, output z_ready, data, strb, valid);
  modport slave (output z_data, z_valid, ready, input z_ready, data, strb, valid);
endinterface

// File: rtl/redmule_z_tile_cnt.sv
// redmule_z_tile_cnt: nested row/column-tile/row-block counters advancing per accepted Z row; last_col_o flags the last column tile
module redmule_z_tile_cnt
  import redmule_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] n_col_tiles_i,
  input  logic [CNT_W-1:0] n_row_blocks_i,
  input  logic [7:0]       rows_lftovr_i,
  output logic             last_col_o
);
  logic [CNT_W-1:0] row_q, col_q, blk_q, rows_in_tile;
  logic             last_blk, row_wrap;
  always_comb begin
    last_col_o   = ({1'b0, col_q} + 17'd1) >= {1'b0, n_col_tiles_i};
    last_blk     = ({1'b0, blk_q} + 17'd1) >= {1'b0, n_row_blocks_i};
    rows_in_tile = (last_blk && rows_lftovr_i != 8'd0) ? {8'd0, rows_lftovr_i} : CNT_W'(ARRAY_WIDTH);
    row_wrap     = ({1'b0, row_q} + 17'd1) >= {1'b0, rows_in_tile};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || load_i) begin
      row_q <= '0;
      col_q <= '0;
      blk_q <= '0;
    end else if (en_i) begin
      row_q <= row_wrap ? '0 : row_q + 1'b1;
      col_q <= row_wrap ? (last_col_o ? '0 : col_q + 1'b1) : col_q;
      blk_q <= (row_wrap && last_col_o) ? blk_q + 1'b1 : blk_q;
    end
  end
endmodule

// File: rtl/redmule_z_store_packer.sv
// redmule_z_store_packer: packs Z rows (z_if z_*) into strobed TCDM store beats (z_if data/strb/valid/ready); start_i + config in, busy_o/done_o out
module redmule_z_store_packer
  import redmule_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [CNT_W-1:0]          tot_stores_i,
  input  logic [CNT_W-1:0]          n_col_tiles_i,
  input  logic [CNT_W-1:0]          n_row_blocks_i,
  input  logic [7:0]                cols_lftovr_i,
  input  logic [7:0]                rows_lftovr_i,
  redmule_z_store_packer_if.master  z_if,
  output logic                      busy_o,
  output logic                      done_o
);
  z_packer_state_e   state_q, state_d;
  z_packer_cfg_t     cfg_q, cfg_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [STRB-1:0]   strb_q, strb_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d, store_cnt_q, store_cnt_d;
  logic              run, start_ok, in_xfer, out_xfer, last_out, last_col;
  redmule_z_tile_cnt i_tile_cnt (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clr_i          (clear_i),
    .load_i         (start_ok),
    .en_i           (in_xfer),
    .n_col_tiles_i  (cfg_q.n_col_tiles),
    .n_row_blocks_i (cfg_q.n_row_blocks),
    .rows_lftovr_i  (cfg_q.rows_lftovr),
    .last_col_o     (last_col)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) state_q <= IDLE;
    else                  state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (start_i ? (tot_stores_i == '0 ? DONE : RUN) : IDLE)
            : (state_q == RUN)  ? (last_out ? DONE : RUN)
            : IDLE;
  end
  always_comb begin
    busy_o = state_q != IDLE;
    done_o = state_q == DONE;
    run    = state_q == RUN;
  end
  // input is closed once tot_stores rows have entered, so surplus rows stay in the Z buffer
  always_comb begin
    start_ok     = (state_q == IDLE) && start_i;
    z_if.z_ready = run && (in_cnt_q < cfg_q.tot_stores) && (!valid_q || z_if.ready);
    in_xfer      = z_if.z_valid && z_if.z_ready;
    out_xfer     = valid_q && z_if.ready;
    last_out     = out_xfer && (store_cnt_q == cfg_q.tot_stores - 16'd1);
    cfg_d        = start_ok ? z_packer_cfg_t'{tot_stores_i, n_col_tiles_i, n_row_blocks_i, cols_lftovr_i, rows_lftovr_i} : cfg_q;
    valid_d      = in_xfer || (valid_q && !z_if.ready);
    data_d       = in_xfer ? {{MEM_DW{1'b0}}, z_if.z_data} : data_q;
    strb_d       = in_xfer ? col_strb(last_col ? cfg_q.cols_lftovr : 8'd0) : strb_q;
    in_cnt_d     = start_ok ? '0 : in_cnt_q + CNT_W'(in_xfer);
    store_cnt_d  = start_ok ? '0 : store_cnt_q + CNT_W'(out_xfer);
    z_if.valid   = valid_q;
    z_if.data    = data_q;
    z_if.strb    = strb_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cfg_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      strb_q      <= '0;
      in_cnt_q    <= '0;
      store_cnt_q <= '0;
    end else begin
      cfg_q       <= cfg_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      in_cnt_q    <= in_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end
endmodule

// File: tb/tb_redmule_z_store_packer.sv
// tb_redmule_z_store_packer: scoreboard bench for the Z store packer
module tb_redmule_z_store_packer;
  import redmule_pkg::*;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, start = 1'b0;
  logic [15:0] tot = '0, ncol = '0, nrb = '0;
  logic [7:0] cl = '0, rl = '0;
  logic busy, done;
  int tests = 0, fails = 0;
  logic [STRB-1:0] strb_list[$];
  logic [STRB-1:0] exp_s_q[$];
  logic [DATA_W-1:0] exp_d_q[$];
  redmule_z_store_packer_if bus();
  redmule_z_store_packer dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
    .tot_stores_i(tot), .n_col_tiles_i(ncol), .n_row_blocks_i(nrb),
    .cols_lftovr_i(cl), .rows_lftovr_i(rl),
    .z_if(bus), .busy_o(busy), .done_o(done)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic logic [STRB-1:0] mask(input int n);
    logic [63:0] m;
    m = (64'd1 << (2 * n)) - 64'd1;
    return m[STRB-1:0];
  endfunction
  // expected strobe of every beat, from a plain nested walk over blocks/tiles/rows
  function automatic void build();
    int k, nc, nb, c_eff;
    k = 0; nc = int'(ncol); nb = int'(nrb);
    c_eff = (int'(cl) > 16) ? 16 : int'(cl);
    strb_list.delete();
    for (int b = 0; k < int'(tot); b++)
      for (int c = 0; c < nc && k < int'(tot); c++) begin
        int rows;
        rows = (b >= nb - 1 && rl != 0) ? int'(rl) : 12;
        for (int r = 0; r < rows && k < int'(tot); r++) begin
          strb_list.push_back((c == nc - 1 && cl != 0) ? mask(c_eff) : mask(16));
          k++;
        end
      end
  endfunction
  task automatic start_run(input int t, input int c, input int b, input int cls, input int rls);
    @(negedge clk);
    tot = 16'(t); ncol = 16'(c); nrb = 16'(b); cl = 8'(cls); rl = 8'(rls);
    start = 1'b1;
    build();
    exp_d_q.delete(); exp_s_q.delete();
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic run(input int n, input bit rand_rdy, input bit rand_val, input int abort_at,
                     input bit poke_start, output int cycles);
    int sent, got;
    bit stalled;
    logic [DATA_W-1:0] hd, ed;
    logic [STRB-1:0] hs, es;
    sent = 0; got = 0; stalled = 0; cycles = 0; hd = '0; hs = '0;
    while (got < n && got != abort_at && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (stalled) begin
        tests++;
        if (bus.data !== hd || bus.strb !== hs) begin
          fails++;
          $display("FAIL stall_hold: strb %h data %h, required strb %h data %h", bus.strb, bus.data, hs, hd);
        end
      end
      start = poke_start && cycles == 4;
      if (poke_start && cycles == 4) tot = 16'd3;
      bus.ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.z_valid = rand_val ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      bus.z_data = {8{$urandom()}};
      #1;
      tests++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL early_done: done_o %b after %0d beats, required 0", done, got);
      end
      if (bus.valid && !bus.ready) begin
        tests++;
        if (bus.z_ready !== 1'b0) begin
          fails++;
          $display("FAIL stall_zready: z_ready_o %b while stalled, required 0", bus.z_ready);
        end
      end
      if (bus.valid && bus.ready) begin
        tests++;
        if (exp_d_q.size() == 0) begin
          fails++;
          $display("FAIL extra_beat: beat %0d produced with nothing expected", got);
        end else begin
          ed = exp_d_q.pop_front();
          es = exp_s_q.pop_front();
          if (bus.data !== ed || bus.strb !== es) begin
            fails++;
            $display("FAIL beat%0d: strb %h data %h, required strb %h data %h", got, bus.strb, bus.data, es, ed);
          end
        end
        got++;
      end
      stalled = bus.valid && !bus.ready;
      hd = bus.data; hs = bus.strb;
      if (bus.z_valid && bus.z_ready) begin
        if (sent >= n) begin
          tests++; fails++;
          $display("FAIL surplus: row %0d accepted, required z_ready_o=0 after %0d rows", sent, n);
        end else begin
          exp_d_q.push_back({{MEM_DW{1'b0}}, bus.z_data});
          exp_s_q.push_back(strb_list[sent]);
        end
        sent++;
      end
      @(posedge clk);
    end
    bus.z_valid = 1'b0; bus.ready = 1'b1; start = 1'b0;
    if (abort_at < 0) begin
      tests++;
      if (got != n) begin
        fails++;
        $display("FAIL beat_count: %0d beats, required %0d", got, n);
      end
    end
  endtask
  task automatic check_done(input string name);
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b1 || bus.valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_done: done %b busy %b valid %b, required 1 1 0", name, done, busy, bus.valid);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: done %b busy %b, required 0 0", name, done, busy);
    end
  endtask
  task automatic test_reset();
    bus.z_valid = 1'b0; bus.z_data = '0; bus.ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    tests++;
    if (bus.valid !== 1'b0 || bus.data !== '0 || bus.strb !== '0 || busy !== 1'b0 || done !== 1'b0 || bus.z_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset: valid %b data %h strb %h busy %b done %b z_ready %b, required all 0",
               bus.valid, bus.data, bus.strb, busy, done, bus.z_ready);
    end
  endtask
  task automatic test_basic();
    int cyc;
    start_run(24, 2, 1, 0, 0);
    run(24, 0, 0, -1, 0, cyc);
    tests++;
    if (cyc != 25) begin
      fails++;
      $display("FAIL basic_throughput: %0d cycles for 24 beats, required 25", cyc);
    end
    check_done("basic");
  endtask
  task automatic test_col_lftovr();
    int cyc;
    tests++;
    if (mask(5) !== 36'h0_0000_03FF) begin
      fails++;
      $display("FAIL model_mask: %h, required 0003ff", mask(5));
    end
    start_run(24, 2, 1, 5, 0);
    run(24, 0, 0, -1, 0, cyc);
    check_done("col");
  endtask
  task automatic test_row_lftovr();
    int cyc;
    start_run(15, 1, 2, 0, 3);
    run(15, 0, 0, -1, 0, cyc);
    check_done("row");
    start_run(30, 2, 2, 5, 3);
    run(30, 0, 0, -1, 0, cyc);
    check_done("rowcol");
  endtask
  task automatic test_backpressure();
    int cyc;
    start_run(40, 3, 2, 7, 5);
    run(40, 1, 1, -1, 0, cyc);
    check_done("bp");
  endtask
  task automatic test_edge();
    int cyc;
    start_run(0, 1, 1, 0, 0);
    check_done("zero");
    start_run(12, 1, 1, 20, 0);
    run(12, 0, 0, -1, 0, cyc);
    check_done("sat");
    start_run(24, 2, 1, 5, 0);
    run(24, 0, 0, -1, 1, cyc);
    check_done("restart_ignored");
  endtask
  task automatic test_reset_mid();
    int cyc;
    start_run(24, 2, 1, 0, 0);
    run(24, 0, 0, 7, 0, cyc);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: valid %b busy %b done %b, required 0 0 0", bus.valid, busy, done);
    end
    rst = 1'b0;
    start_run(24, 2, 1, 0, 0);
    run(24, 1, 0, -1, 0, cyc);
    check_done("after_reset");
  endtask
  initial begin
    test_reset();
    test_basic();
    test_col_lftovr();
    test_row_lftovr();
    test_backpressure();
    test_edge();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
